vqueue_cmd_parser: RTL

Command-stream parser that drains 32-bit words from the video command queue (vqueue) and turns them into framed command beats for the graphics pipeline. Each command is one header word followed by 0..255 payload words. The parser pops words from the queue's read side and presents every payload word with its opcode and first/last framing on a valid/ready output port. It sits directly downstream of the queue, in the read-clock domain.

---
 rtl/vqueue_cmd_parser.sv | 113 +++++++++++
 1 files changed

// File: rtl/vqueue_cmd_parser.sv
// rtl/vqueue_cmd_parser.sv - vqueue command parser: header/payload words to framed output beats
// Pops show-ahead queue words, one pop per two cycles, and emits opcode-tagged payload beats.

module vqueue_cmd_parser #(
  parameter int len_width    = 8,
  parameter int opcode_width = 8,
  parameter int count_width  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             q_data,
  input  logic                    q_empty,
  output logic                    q_rd_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [opcode_width-1:0] out_opcode,
  output logic [31:0]             out_data,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    out_nodata,
  output logic                    busy,
  output logic [count_width-1:0]  cmd_count
);

  typedef enum logic {HDR, PAY} state_t;

  state_t                  state;
  logic [opcode_width-1:0] opcode_r;
  logic [len_width-1:0]    remaining;
  logic                    first_pend;
  logic                    settle;

  logic                    slot_free;
  logic                    pop_ok;
  logic                    hdr_zero;
  logic [opcode_width-1:0] hdr_op;
  logic [len_width-1:0]    hdr_len;

  assign hdr_op    = q_data[31 -: opcode_width];
  assign hdr_len   = q_data[len_width-1:0];
  assign hdr_zero  = (hdr_len == '0);
  assign slot_free = !out_valid || out_ready;
  // The queue outputs are stale for one cycle after each pop, hence the settle gate.
  assign pop_ok    = !reset && !q_empty && !settle;
  assign busy      = (state == PAY);

  always_comb begin
    q_rd_en = 1'b0;
    case (state)
      HDR:     q_rd_en = pop_ok && (!hdr_zero || slot_free);
      PAY:     q_rd_en = pop_ok && slot_free;
      default: q_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HDR;
      opcode_r   <= '0;
      remaining  <= '0;
      first_pend <= 1'b0;
      settle     <= 1'b0;
      out_valid  <= 1'b0;
      out_opcode <= '0;
      out_data   <= '0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      out_nodata <= 1'b0;
      cmd_count  <= '0;
    end else begin
      settle <= q_rd_en;

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        if (out_last) cmd_count <= cmd_count + count_width'(1);
      end

      // A load in the same cycle as an acceptance overrides the clear above.
      if (q_rd_en) begin
        case (state)
          HDR: begin
            if (hdr_zero) begin
              out_valid  <= 1'b1;
              out_opcode <= hdr_op;
              out_data   <= '0;
              out_first  <= 1'b1;
              out_last   <= 1'b1;
              out_nodata <= 1'b1;
            end else begin
              opcode_r   <= hdr_op;
              remaining  <= hdr_len;
              first_pend <= 1'b1;
              state      <= PAY;
            end
          end
          PAY: begin
            out_valid  <= 1'b1;
            out_opcode <= opcode_r;
            out_data   <= q_data;
            out_first  <= first_pend;
            out_last   <= (remaining == len_width'(1));
            out_nodata <= 1'b0;
            first_pend <= 1'b0;
            remaining  <= remaining - len_width'(1);
            if (remaining == len_width'(1)) state <= HDR;
          end
          default: state <= HDR;
        endcase
      end
    end
  end

endmodule
